// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode, the ID/EX register and the ALU/bypass network.
// The master side drives decode, MEM and WB inputs; the slave side is the stage.
interface id_ex_stage_if #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
);
   logic              hold;
   logic              flush;
   logic              id_valid;
   logic [DATA_W-1:0] id_pc;
   logic [DATA_W-1:0] id_imm;
   logic [RA_W-1:0]   id_rs1;
   logic [RA_W-1:0]   id_rs2;
   logic [RA_W-1:0]   id_rd;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [DATA_W-1:0] id_rs1_val;
   logic [DATA_W-1:0] id_rs2_val;
   logic [3:0]        id_alu_op;
   logic              id_src_pc;
   logic              id_src_imm;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic [RA_W-1:0]   mem_rd;
   logic              mem_reg_write;
   logic [DATA_W-1:0] mem_result;
   logic [RA_W-1:0]   wb_rd;
   logic              wb_reg_write;
   logic [DATA_W-1:0] wb_data;
   logic              stall_id;
   logic              ex_valid;
   logic [3:0]        ex_alu_op;
   logic [DATA_W-1:0] ex_x;
   logic [DATA_W-1:0] ex_y;
   logic [DATA_W-1:0] ex_store_data;
   logic [DATA_W-1:0] ex_pc;
   logic [RA_W-1:0]   ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [15:0]       bubble_cnt;

   modport master (
      output hold, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_rs1_val, id_rs2_val, id_alu_op,
             id_src_pc, id_src_imm, id_reg_write, id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
      input  stall_id, ex_valid, ex_alu_op, ex_x, ex_y, ex_store_data, ex_pc,
             ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, bubble_cnt
   );

   modport slave (
      input  hold, flush, id_valid, id_pc, id_imm, id_rs1, id_rs2, id_rd,
             id_use_rs1, id_use_rs2, id_rs1_val, id_rs2_val, id_alu_op,
             id_src_pc, id_src_imm, id_reg_write, id_mem_read, id_mem_write,
             mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
      output stall_id, ex_valid, ex_alu_op, ex_x, ex_y, ex_store_data, ex_pc,
             ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, bubble_cnt
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass, load-use bubble insertion,
// branch flush and a saturating bubble counter.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   id_ex_stage_if.slave  bus
);
   logic              valid_reg;
   logic [DATA_W-1:0] pc_reg;
   logic [DATA_W-1:0] imm_reg;
   logic [RA_W-1:0]   rs_reg [2];
   logic [DATA_W-1:0] rs_val_reg [2];
   logic [RA_W-1:0]   rd_reg;
   logic [3:0]        alu_op_reg;
   logic              src_pc_reg;
   logic              src_imm_reg;
   logic              reg_write_reg;
   logic              mem_read_reg;
   logic              mem_write_reg;
   logic [15:0]       bubble_cnt_reg;
   logic [15:0]       bubble_cnt_next;

   logic [RA_W-1:0]   id_rs [2];
   logic              id_use [2];
   logic [DATA_W-1:0] id_rs_val [2];
   logic [1:0]        rs_hit;
   logic [DATA_W-1:0] cap_val [2];
   logic [DATA_W-1:0] fwd [2];
   logic              haz;

   assign id_rs[0]     = bus.id_rs1;
   assign id_rs[1]     = bus.id_rs2;
   assign id_use[0]    = bus.id_use_rs1;
   assign id_use[1]    = bus.id_use_rs2;
   assign id_rs_val[0] = bus.id_rs1_val;
   assign id_rs_val[1] = bus.id_rs2_val;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         assign rs_hit[gi] = id_use[gi] && (rd_reg == id_rs[gi]);
         // Write-through: the register file write lands this same cycle.
         assign cap_val[gi] = (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == id_rs[gi])
                              ? bus.wb_data : id_rs_val[gi];
         always_comb begin
            fwd[gi] = rs_val_reg[gi];
            if (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == rs_reg[gi])
               fwd[gi] = bus.mem_result;
            else if (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == rs_reg[gi])
               fwd[gi] = bus.wb_data;
         end
      end
   endgenerate

   assign haz = bus.id_valid && valid_reg && mem_read_reg && (rd_reg != '0) && (|rs_hit);
   assign bubble_cnt_next = (bubble_cnt_reg == 16'hFFFF) ? bubble_cnt_reg : bubble_cnt_reg + 16'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg      <= 1'b0;
         pc_reg         <= '0;
         imm_reg        <= '0;
         rd_reg         <= '0;
         alu_op_reg     <= '0;
         src_pc_reg     <= 1'b0;
         src_imm_reg    <= 1'b0;
         reg_write_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         bubble_cnt_reg <= '0;
         for (int i = 0; i < 2; i++) begin
            rs_reg[i]     <= '0;
            rs_val_reg[i] <= '0;
         end
      end else if (bus.hold) begin
         // Frozen pipeline: everything keeps its value.
      end else if (bus.flush || haz) begin
         valid_reg      <= 1'b0;
         rd_reg         <= '0;
         alu_op_reg     <= '0;
         reg_write_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         bubble_cnt_reg <= bubble_cnt_next;
      end else begin
         valid_reg      <= bus.id_valid;
         pc_reg         <= bus.id_pc;
         imm_reg        <= bus.id_imm;
         rd_reg         <= bus.id_rd;
         alu_op_reg     <= bus.id_alu_op;
         src_pc_reg     <= bus.id_src_pc;
         src_imm_reg    <= bus.id_src_imm;
         reg_write_reg  <= bus.id_reg_write & bus.id_valid;
         mem_read_reg   <= bus.id_mem_read & bus.id_valid;
         mem_write_reg  <= bus.id_mem_write & bus.id_valid;
         if (!bus.id_valid)
            bubble_cnt_reg <= bubble_cnt_next;
         for (int i = 0; i < 2; i++) begin
            rs_reg[i]     <= id_rs[i];
            rs_val_reg[i] <= cap_val[i];
         end
      end
   end

   assign bus.stall_id      = haz & ~bus.flush & ~bus.hold;
   assign bus.ex_valid      = valid_reg;
   assign bus.ex_alu_op     = alu_op_reg;
   assign bus.ex_x          = src_pc_reg ? pc_reg : fwd[0];
   assign bus.ex_y          = src_imm_reg ? imm_reg : fwd[1];
   assign bus.ex_store_data = fwd[1];
   assign bus.ex_pc         = pc_reg;
   assign bus.ex_rd         = rd_reg;
   assign bus.ex_reg_write  = reg_write_reg;
   assign bus.ex_mem_read   = mem_read_reg;
   assign bus.ex_mem_write  = mem_write_reg;
   assign bus.bubble_cnt    = bubble_cnt_reg;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline register and operand-forwarding stage of the RISC-V core. Captures decoded instructions and drives the ALU's AluOP, X and Y inputs directly. Resolves RAW hazards by bypassing from the MEM and WB stages, and inserts a one-cycle bubble on load-use. Squashes its content on branch/jump flush and counts bubble cycles for the VGA debug overlay.

## Interface
- DATA_W, 32, datapath width (fixed 32 for RV32I)
- RA_W, 5, register address width

- CLK  in  1  rising-edge clock
- RST_N  in  1  reset; asynchronous, active-low
- hold  in  1  global pipeline freeze (halt/ecall)
- flush  in  1  squash current ID instruction (taken branch/jump resolved in EX)
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_imm  in  32  instruction PC, sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_val, id_rs2_val  in  32  register-file read data
- id_alu_op  in  4  ALU operation code
- id_src_pc, id_src_imm  in  1  X=PC instead of rs1; Y=imm instead of rs2
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- mem_rd  in  RA_W, mem_reg_write  in  1, mem_result  in  32  EX/MEM stage destination and ALU result
- wb_rd  in  RA_W, wb_reg_write  in  1, wb_data  in  32  register-file write port
- stall_id  out  1  hold PC and IF/ID this cycle (load-use)
- ex_valid  out  1  EX slot valid
- ex_alu_op  out  4  to ALU AluOP
- ex_x, ex_y  out  32  to ALU X, Y (combinational after forwarding)
- ex_store_data  out  32  forwarded rs2 for stores
- ex_pc  out  32, ex_rd  out  RA_W, ex_reg_write / ex_mem_read / ex_mem_write  out  1
- bubble_cnt  out  16  saturating count of bubble cycles

## Operation
- Registered fields: valid, pc, imm, rs1, rs2, rd, rs1_val, rs2_val, alu_op, src_pc, src_imm, reg_write, mem_read, mem_write.
- Hazard: haz = id_valid & ex_valid & ex_mem_read & (ex_rd≠0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)). stall_id = haz & ~flush & ~hold.
- Per-edge priority: RST_N low > hold > flush > haz > load.
  - hold: all registers and bubble_cnt keep their values.
  - flush or haz: insert a bubble. valid, reg_write, mem_read, mem_write, rd and alu_op are cleared; data fields hold; bubble_cnt += 1, saturating at 0xFFFF.
  - load: capture all id_* fields. valid = id_valid. Control bits are ANDed with id_valid. If id_valid=0, bubble_cnt += 1.
- Regfile write-through at capture: if wb_reg_write & wb_rd≠0 & wb_rd==id_rsN, capture wb_data instead of id_rsN_val.
- EX forwarding, combinational on registered rsN, rsN_val:
  - fwdN = mem_result if mem_reg_write & mem_rd≠0 & mem_rd==rsN.
  - Else wb_data if wb_reg_write & wb_rd≠0 & wb_rd==rsN.
  - Else rsN_val. MEM has priority over WB.
- ex_x = src_pc ? pc : fwd1. ex_y = src_imm ? imm : fwd2. ex_store_data = fwd2.
- Register x0 is never forwarded and never triggers a hazard.

## Timing
- Reset values: every register, bubble_cnt, ex_valid and all control outputs are 0. stall_id is 0 whenever ex_valid=0.
- Latency: 1 cycle from ID capture to ex_* registered outputs. ex_x, ex_y and ex_store_data add only combinational forwarding delay within the same cycle.
- Load-use: exactly one bubble. On the next cycle the load is in MEM, the hazard clears and the dependent is captured. One cycle later its operand comes from WB.
- flush in the same cycle as haz: a single bubble, stall_id=0, so upstream advances to the redirected PC.
- hold in the same cycle as flush: nothing changes. flush remains asserted because the branch is still held in EX.
- RST_N asserted mid-stream: outputs clear immediately, asynchronously. The first capture happens on the first rising edge after deassertion.

## Test plan
- Reset: RST_N=0 with random id_* inputs → all ex_* outputs 0, bubble_cnt=0, stall_id=0. Release, then id_valid=1, alu_op=5, rs1_val=3, rs2_val=4 → next cycle ex_valid=1, ex_alu_op=5, ex_x=3, ex_y=4.
- Forwarding priority: EX holds rs1=x5 with stale value 1; mem_rd=5 with mem_result=0x10; wb_rd=5 with wb_data=0x20 → ex_x=0x10. Drop mem_reg_write → ex_x=0x20. Set rs1=x0 with both sources matching → ex_x = registered value.
- Load-use: lw x6 in EX; ID `add x7,x6,x1` → stall_id=1 for one cycle, then ex_valid=0 for one cycle with bubble_cnt incremented. The following cycle the add is in EX and ex_x=wb_data.
- Flush with hazard: the same load-use setup plus flush=1 → stall_id=0, next cycle ex_valid=0 and ex_reg_write=0, bubble_cnt +1.
- Hold: hold=1 for 3 cycles while id_* inputs change → ex_* and bubble_cnt are unchanged. After release, normal capture resumes.
- Saturation and write-through: force 0x10000+ bubbles → bubble_cnt stays at 0xFFFF. Capture with wb_rd==id_rs2=9, wb_data=0xAB → ex_store_data=0xAB.
